inst_data_arbiter: RTL and testbench

INST_DATA_ARBITER -- requirements
Module: inst_data_arbiter

---
 rtl/inst_data_arbiter.sv | 144 ++++++++++++++
 tb/tb_inst_data_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_data_arbiter.sv
// Two-requester (fetch / MEM) arbiter onto a single SRAM-like bus, one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (data wins).
module inst_data_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_kill,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_idle;
    logic        w_data_valid;
    logic        w_pick_data;
    logic        w_grant_inst;
    logic        w_grant_data;
    logic        w_complete;

    assign w_data_valid = data_req & ~data_kill;
    // Reset is asynchronous, so grants are also masked while it is held.
    assign w_idle       = (r_state == S_IDLE) & rst;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t r_last_grant;

    assign w_pick_data = w_data_valid & (~inst_req | (r_last_grant == OWN_INST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= OWN_INST;
        end else if (w_grant_data) begin
            r_last_grant <= OWN_DATA;
        end else if (w_grant_inst) begin
            r_last_grant <= OWN_INST;
        end
    end
`else
    assign w_pick_data = w_data_valid;
`endif

    assign w_grant_data = w_idle & w_pick_data;
    assign w_grant_inst = w_idle & inst_req & ~w_pick_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_data || w_grant_inst) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_data) begin
                r_owner <= OWN_DATA;
                r_wr    <= data_wr;
                r_size  <= data_size;
                r_addr  <= data_addr;
                r_wdata <= data_wdata;
            end else if (w_grant_inst) begin
                r_owner <= OWN_INST;
                r_wr    <= 1'b0;
                r_size  <= 2'b10;
                r_addr  <= inst_addr;
                r_wdata <= 32'h0;
            end
        end
    end

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_data_ok = w_complete & (r_owner == OWN_INST);
    assign data_data_ok = w_complete & (r_owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'h0;

    assign bus_req   = (r_state == S_ADDR);
    assign bus_wr    = bus_req & r_wr;
    assign bus_size  = bus_req ? r_size  : 2'b00;
    assign bus_addr  = bus_req ? r_addr  : 32'h0;
    assign bus_wdata = bus_req ? r_wdata : 32'h0;

endmodule

// File: tb/tb_inst_data_arbiter.sv
// Cycle-by-cycle vector bench for inst_data_arbiter, plus hand-written reset-in-WAIT and
// post-reset arbitration sequences. Expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_inst_data_arbiter;

    localparam logic [31:0] IA = 32'hBFC00000;
    localparam logic [31:0] DA = 32'h80001000;
    localparam logic [31:0] DW = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr, data_kill;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    inst_data_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_kill    (data_kill),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    // ok bits: {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req, bus_wr}
    typedef struct {
        logic        ireq, dreq, kill, aok, dok;
        logic [31:0] rdata_in;
        logic [5:0]  ok;
        logic [31:0] baddr;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mkv(input logic ireq, dreq, kill, aok, dok,
                                 input logic [31:0] rdata_in, input logic [5:0] ok,
                                 input logic [31:0] baddr, rd);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.kill = kill; v.aok = aok; v.dok = dok;
        v.rdata_in = rdata_in; v.ok = ok; v.baddr = baddr; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ok_bits();
        return {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req, bus_wr};
    endfunction

    // Full output check; bus size/wdata and the rdata ports follow from the ok bits.
    task automatic check_all(input string tag, input logic [5:0] ok,
                             input logic [31:0] baddr, input logic [31:0] rd);
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        exp_size  = ok[1] ? (ok[0] ? 2'b01 : 2'b10) : 2'b00;
        exp_wdata = (ok[1] && ok[0]) ? DW : 32'h0;
        check({tag, ".ok"},    {26'h0, ok_bits()}, {26'h0, ok});
        check({tag, ".baddr"}, bus_addr, baddr);
        check({tag, ".bsize_wdata"}, bus_wdata ^ {30'h0, bus_size}, exp_wdata ^ {30'h0, exp_size});
        check({tag, ".irdata"}, inst_rdata, ok[3] ? rd : 32'h0);
        check({tag, ".drdata"}, data_rdata, ok[2] ? rd : 32'h0);
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        logic [2:0] exp_data_grant = 3'b101;
`else
        logic [2:0] exp_data_grant = 3'b111;
`endif
        vecs[0]  = mkv(1,0,0,0,0, 32'h0,        6'b100000, 32'h0, 32'h0);
        vecs[1]  = mkv(0,0,0,1,0, 32'h0,        6'b000010, IA,    32'h0);
        vecs[2]  = mkv(0,0,0,0,0, 32'h0,        6'b000000, 32'h0, 32'h0);
        vecs[3]  = mkv(0,0,0,0,1, 32'h3C080001, 6'b001000, 32'h0, 32'h3C080001);
        vecs[4]  = mkv(0,0,0,1,1, 32'h12345678, 6'b000000, 32'h0, 32'h0);
        vecs[5]  = mkv(0,1,0,0,0, 32'h0,        6'b010000, 32'h0, 32'h0);
        vecs[6]  = mkv(0,0,0,1,1, 32'hCAFE0001, 6'b000111, DA,    32'hCAFE0001);
        vecs[7]  = mkv(0,0,0,0,0, 32'h0,        6'b000000, 32'h0, 32'h0);
        vecs[8]  = mkv(0,1,0,0,0, 32'h0,        6'b010000, 32'h0, 32'h0);
        vecs[9]  = mkv(0,1,0,1,1, 32'h11,       6'b000111, DA,    32'h11);
        vecs[10] = mkv(0,1,0,0,0, 32'h0,        6'b010000, 32'h0, 32'h0);
        vecs[11] = mkv(0,0,0,1,1, 32'h22,       6'b000111, DA,    32'h22);
        vecs[12] = mkv(0,1,1,0,0, 32'h0,        6'b000000, 32'h0, 32'h0);
        vecs[13] = mkv(0,1,1,0,0, 32'h0,        6'b000000, 32'h0, 32'h0);
        vecs[14] = mkv(0,1,0,0,0, 32'h0,        6'b010000, 32'h0, 32'h0);
        vecs[15] = mkv(0,1,1,1,0, 32'h0,        6'b000011, DA,    32'h0);
        vecs[16] = mkv(0,0,1,0,1, 32'h33,       6'b000100, 32'h0, 32'h33);
        vecs[17] = mkv(1,1,1,0,0, 32'h0,        6'b100000, 32'h0, 32'h0);
        vecs[18] = mkv(0,0,0,1,1, 32'h44,       6'b001010, IA,    32'h44);
        vecs[19] = mkv(1,1,0,0,0, 32'h0,        6'b010000, 32'h0, 32'h0);
        vecs[20] = mkv(1,1,0,1,1, 32'h55,       6'b000111, DA,    32'h55);
`ifdef ARB_ROUND_ROBIN_EN
        vecs[21] = mkv(1,1,0,0,0, 32'h0,        6'b100000, 32'h0, 32'h0);
        vecs[22] = mkv(1,1,0,1,1, 32'h66,       6'b001010, IA,    32'h66);
`else
        vecs[21] = mkv(1,1,0,0,0, 32'h0,        6'b010000, 32'h0, 32'h0);
        vecs[22] = mkv(1,1,0,1,1, 32'h66,       6'b000111, DA,    32'h66);
`endif
        vecs[23] = mkv(1,1,0,0,0, 32'h0,        6'b010000, 32'h0, 32'h0);
        vecs[24] = mkv(0,0,0,1,1, 32'h77,       6'b000111, DA,    32'h77);

        inst_addr  = IA;
        data_addr  = DA;
        data_wdata = DW;
        data_size  = 2'b01;
        data_wr    = 1'b1;
        data_kill  = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;

        // Requests held during reset must not be granted.
        rst = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        #3;
        check_all("reset", 6'b000000, 32'h0, 32'h0);
        @(negedge clk);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            inst_req    = vecs[i].ireq;
            data_req    = vecs[i].dreq;
            data_kill   = vecs[i].kill;
            bus_addr_ok = vecs[i].aok;
            bus_data_ok = vecs[i].dok;
            bus_rdata   = vecs[i].rdata_in;
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].ok, vecs[i].baddr, vecs[i].rd);
        end

        // Reset asserted while waiting for data: transaction is abandoned immediately.
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b1; data_kill = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        #2 check_all("rstw.grant", 6'b010000, 32'h0, 32'h0);
        @(negedge clk);
        data_req = 1'b0; bus_addr_ok = 1'b1;
        #2 check_all("rstw.addr", 6'b000011, DA, 32'h0);
        @(negedge clk);
        bus_addr_ok = 1'b0;
        rst = 1'b0;
        #1 check_all("rstw.async", 6'b000000, 32'h0, 32'h0);
        bus_data_ok = 1'b1; bus_rdata = 32'h99;
        #1 check_all("rstw.dok", 6'b000000, 32'h0, 32'h0);
        @(negedge clk);
        bus_data_ok = 1'b0; inst_req = 1'b1; data_req = 1'b1;
        #1 check_all("rstw.held", 6'b000000, 32'h0, 32'h0);

        // Post-reset, both requesters valid for three transactions.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
            #2 check_all($sformatf("both%0d.grant", i),
                         exp_data_grant[i] ? 6'b010000 : 6'b100000, 32'h0, 32'h0);
            @(negedge clk);
            bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hA000 + i;
            #2 check_all($sformatf("both%0d.done", i),
                         exp_data_grant[i] ? 6'b000111 : 6'b001010,
                         exp_data_grant[i] ? DA : IA, 32'hA000 + i);
        end

        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #2;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
